// File: rtl/a2d_sched_pkg.sv
// rtl/a2d_sched_pkg.sv - shared types, widths and command helpers for the A2D round-robin scheduler
package a2d_sched_pkg;

    localparam int RES_W = 12;
    localparam int CMD_W = 16;

    localparam logic [2:0] CH_LFT  = 3'd0;
    localparam logic [2:0] CH_RGHT = 3'd4;
    localparam logic [2:0] CH_BATT = 3'd5;

    typedef enum logic [1:0] {IDLE, CNV, GAP, RD} state_t;
    typedef enum logic [1:0] {PTR_LFT, PTR_RGHT, PTR_BATT} ptr_t;

    function automatic logic [CMD_W-1:0] mk_cmd(input logic [2:0] chnl);
        return {2'b00, chnl, 11'h000};
    endfunction

    function automatic logic [2:0] ptr_chnl(input ptr_t p);
        case (p)
            PTR_RGHT: return CH_RGHT;
            PTR_BATT: return CH_BATT;
            default:  return CH_LFT;
        endcase
    endfunction

    function automatic ptr_t ptr_next(input ptr_t p);
        case (p)
            PTR_LFT:  return PTR_RGHT;
            PTR_RGHT: return PTR_BATT;
            default:  return PTR_LFT;
        endcase
    endfunction

endpackage

// File: rtl/a2d_sched_if.sv
// rtl/a2d_sched_if.sv - core/SPI-master/result signal bundle of the A2D scheduler
interface a2d_sched_if;
    import a2d_sched_pkg::*;

    logic             nxt;
    logic             wrt;
    logic [CMD_W-1:0] cmd;
    logic             done;
    logic [15:0]      rd_data;
    logic [RES_W-1:0] lft_ld;
    logic [RES_W-1:0] rght_ld;
    logic [RES_W-1:0] batt;
    logic [2:0]       upd;
    logic             busy;
    logic             ovrn;
    logic             err;

    modport slave (
        input  nxt, done, rd_data,
        output wrt, cmd, lft_ld, rght_ld, batt, upd, busy, ovrn, err
    );

    modport master (
        output nxt, done, rd_data,
        input  wrt, cmd, lft_ld, rght_ld, batt, upd, busy, ovrn, err
    );

endinterface

// File: rtl/a2d_wdog.sv
// rtl/a2d_wdog.sv - per-transaction timeout counter; expire fires when the budget runs out
module a2d_wdog #(
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (run) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign expire = run && !clr && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/a2d_sched.sv
// rtl/a2d_sched.sv - round-robin SPI A2D scheduler (lft/rght/batt); A2D_SCHED_TIMEOUT_EN adds a transaction watchdog
module a2d_sched
    import a2d_sched_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic         clk,
    input  logic         rst,
    a2d_sched_if.slave   sif
);

    state_t           r_state, w_state_nxt;
    ptr_t             r_ptr, w_ptr_nxt;
    logic             r_wrt, w_wrt_nxt;
    logic [CMD_W-1:0] r_cmd, w_cmd_nxt;
    logic [RES_W-1:0] r_lft, w_lft_nxt;
    logic [RES_W-1:0] r_rght, w_rght_nxt;
    logic [RES_W-1:0] r_batt, w_batt_nxt;
    logic [2:0]       r_upd, w_upd_nxt;
    logic             r_ovrn, w_ovrn_nxt;
    logic             r_err, w_err_nxt;
    logic             w_expire;
    logic             w_unused_rd;

    assign w_unused_rd = ^sif.rd_data[15:12];

`ifdef A2D_SCHED_TIMEOUT_EN
    a2d_wdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (r_wrt),
        .run    ((r_state == CNV) || (r_state == RD)),
        .expire (w_expire)
    );
`else
    localparam int unsigned UNUSED_TIMEOUT_CYC = TIMEOUT_CYC;
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= PTR_LFT;
            r_wrt   <= 1'b0;
            r_cmd   <= '0;
            r_lft   <= '0;
            r_rght  <= '0;
            r_batt  <= '0;
            r_upd   <= '0;
            r_ovrn  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_wrt   <= w_wrt_nxt;
            r_cmd   <= w_cmd_nxt;
            r_lft   <= w_lft_nxt;
            r_rght  <= w_rght_nxt;
            r_batt  <= w_batt_nxt;
            r_upd   <= w_upd_nxt;
            r_ovrn  <= w_ovrn_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_wrt_nxt   = 1'b0;
        w_cmd_nxt   = r_cmd;
        w_lft_nxt   = r_lft;
        w_rght_nxt  = r_rght;
        w_batt_nxt  = r_batt;
        w_upd_nxt   = 3'b000;
        w_ovrn_nxt  = sif.nxt && (r_state != IDLE);
        w_err_nxt   = r_err;
        case (r_state)
            IDLE: begin
                if (sif.nxt) begin
                    w_wrt_nxt   = 1'b1;
                    w_cmd_nxt   = mk_cmd(ptr_chnl(r_ptr));
                    w_state_nxt = CNV;
                end
            end
            CNV: begin
                if (sif.done) begin
                    w_state_nxt = GAP;
                end else if (w_expire) begin
                    w_state_nxt = IDLE;
                    w_ptr_nxt   = ptr_next(r_ptr);
                    w_err_nxt   = 1'b1;
                end
            end
            GAP: begin
                w_wrt_nxt   = 1'b1;
                w_state_nxt = RD;
            end
            RD: begin
                if (sif.done) begin
                    case (r_ptr)
                        PTR_RGHT: begin
                            w_rght_nxt = sif.rd_data[RES_W-1:0];
                            w_upd_nxt  = 3'b010;
                        end
                        PTR_BATT: begin
                            w_batt_nxt = sif.rd_data[RES_W-1:0];
                            w_upd_nxt  = 3'b100;
                        end
                        default: begin
                            w_lft_nxt  = sif.rd_data[RES_W-1:0];
                            w_upd_nxt  = 3'b001;
                        end
                    endcase
                    w_ptr_nxt   = ptr_next(r_ptr);
                    w_state_nxt = IDLE;
                end else if (w_expire) begin
                    w_state_nxt = IDLE;
                    w_ptr_nxt   = ptr_next(r_ptr);
                    w_err_nxt   = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign sif.wrt     = r_wrt;
    assign sif.cmd     = r_cmd;
    assign sif.lft_ld  = r_lft;
    assign sif.rght_ld = r_rght;
    assign sif.batt    = r_batt;
    assign sif.upd     = r_upd;
    assign sif.busy    = (r_state != IDLE);
    assign sif.ovrn    = r_ovrn;
    assign sif.err     = r_err;

endmodule

// File: tb/tb_a2d_sched.sv
// tb/tb_a2d_sched.sv - directed self-checking bench for a2d_sched (define A2D_SCHED_TIMEOUT_EN to cover the watchdog)
module tb_a2d_sched;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    a2d_sched_if sif ();

    a2d_sched #(.TIMEOUT_CYC(16)) dut (
        .clk (clk),
        .rst (rst),
        .sif (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wrt"},  16'(sif.wrt), 16'h0);
        chk({tag, "_cmd"},  sif.cmd, 16'h0000);
        chk({tag, "_lft"},  16'(sif.lft_ld), 16'h0);
        chk({tag, "_rght"}, 16'(sif.rght_ld), 16'h0);
        chk({tag, "_batt"}, 16'(sif.batt), 16'h0);
        chk({tag, "_upd"},  16'(sif.upd), 16'h0);
        chk({tag, "_busy"}, 16'(sif.busy), 16'h0);
        chk({tag, "_ovrn"}, 16'(sif.ovrn), 16'h0);
        chk({tag, "_err"},  16'(sif.err), 16'h0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        tick();
        chk_zero(tag);
        rst = 1'b0;
    endtask

    // One full conversion; ovr injects nxt in CNV and alongside the RD done, spur adds a done in GAP
    task automatic conv(input string tag, input logic [15:0] exp_cmd, input logic [15:0] data,
                        input logic [2:0] exp_upd, input logic ovr, input logic spur);
        sif.nxt = 1'b1;
        tick();
        sif.nxt = 1'b0;
        chk({tag, "_wrt1"}, 16'(sif.wrt), 16'h1);
        chk({tag, "_cmd1"}, sif.cmd, exp_cmd);
        chk({tag, "_busy"}, 16'(sif.busy), 16'h1);
        tick();
        chk({tag, "_wrt_cnv"}, 16'(sif.wrt), 16'h0);
        if (ovr) begin
            sif.nxt = 1'b1;
            tick();
            sif.nxt = 1'b0;
            chk({tag, "_ovrn_cnv"}, 16'(sif.ovrn), 16'h1);
            chk({tag, "_wrt_ovr"},  16'(sif.wrt), 16'h0);
        end
        tick();
        sif.done = 1'b1;
        sif.rd_data = 16'hDEAD;
        tick();
        sif.done = 1'b0;
        chk({tag, "_wrt_gap"}, 16'(sif.wrt), 16'h0);
        chk({tag, "_upd_gap"}, 16'(sif.upd), 16'h0);
        if (spur) sif.done = 1'b1;
        tick();
        sif.done = 1'b0;
        chk({tag, "_wrt2"}, 16'(sif.wrt), 16'h1);
        chk({tag, "_cmd2"}, sif.cmd, exp_cmd);
        chk({tag, "_upd_rd"}, 16'(sif.upd), 16'h0);
        tick();
        tick();
        sif.done = 1'b1;
        sif.rd_data = data;
        sif.nxt = ovr;
        tick();
        sif.done = 1'b0;
        sif.nxt = 1'b0;
        sif.rd_data = 16'h0000;
        chk({tag, "_upd"},     16'(sif.upd), 16'(exp_upd));
        chk({tag, "_ovrn_rd"}, 16'(sif.ovrn), 16'(ovr));
        chk({tag, "_busy_end"}, 16'(sif.busy), 16'h0);
        chk({tag, "_cmd_hold"}, sif.cmd, exp_cmd);
        tick();
        chk({tag, "_upd_clr"}, 16'(sif.upd), 16'h0);
        chk({tag, "_wrt_idle"}, 16'(sif.wrt), 16'h0);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst = 1'b1;
        sif.nxt = 1'b0;
        sif.done = 1'b0;
        sif.rd_data = 16'h0000;
        tick();
        tick();
        chk_zero("rst");
        rst = 1'b0;

        conv("first", 16'h0000, 16'hF123, 3'b001, 1'b0, 1'b0);
        chk("first_lft", 16'(sif.lft_ld), 16'h0123);

        do_reset("rst2");
        conv("rr_l", 16'h0000, 16'h0111, 3'b001, 1'b0, 1'b0);
        conv("rr_r", 16'h2000, 16'h0222, 3'b010, 1'b0, 1'b0);
        conv("rr_b", 16'h2800, 16'h0333, 3'b100, 1'b0, 1'b0);
        chk("rr_lft",  16'(sif.lft_ld),  16'h0111);
        chk("rr_rght", 16'(sif.rght_ld), 16'h0222);
        chk("rr_batt", 16'(sif.batt),    16'h0333);
        conv("rr_wrap", 16'h0000, 16'hA444, 3'b001, 1'b0, 1'b0);
        chk("wrap_lft",  16'(sif.lft_ld),  16'h0444);
        chk("wrap_rght", 16'(sif.rght_ld), 16'h0222);

        conv("ovr", 16'h2000, 16'h0555, 3'b010, 1'b1, 1'b0);
        chk("ovr_rght", 16'(sif.rght_ld), 16'h0555);
        chk("ovr_lft",  16'(sif.lft_ld),  16'h0444);
        chk("ovr_batt", 16'(sif.batt),    16'h0333);

        sif.done = 1'b1;
        sif.rd_data = 16'h0FFF;
        tick();
        sif.done = 1'b0;
        chk("spi_busy", 16'(sif.busy), 16'h0);
        chk("spi_upd",  16'(sif.upd), 16'h0);
        chk("spi_wrt",  16'(sif.wrt), 16'h0);
        chk("spi_lft",  16'(sif.lft_ld), 16'h0444);
        conv("spg", 16'h2800, 16'h0666, 3'b100, 1'b0, 1'b1);
        chk("spg_batt", 16'(sif.batt),    16'h0666);
        chk("spg_rght", 16'(sif.rght_ld), 16'h0555);

        sif.nxt = 1'b1;
        tick();
        sif.nxt = 1'b0;
        chk("rrd_cmd", sif.cmd, 16'h0000);
        tick();
        sif.done = 1'b1;
        tick();
        sif.done = 1'b0;
        tick();
        chk("rrd_wrt2", 16'(sif.wrt), 16'h1);
        rst = 1'b1;
        sif.nxt = 1'b1;
        tick();
        sif.nxt = 1'b0;
        chk_zero("rst_rd");
        rst = 1'b0;
        conv("post_rst", 16'h0000, 16'h0777, 3'b001, 1'b0, 1'b0);
        chk("post_lft",  16'(sif.lft_ld),  16'h0777);
        chk("post_rght", 16'(sif.rght_ld), 16'h0000);

`ifdef A2D_SCHED_TIMEOUT_EN
        do_reset("rst_to");
        sif.nxt = 1'b1;
        tick();
        sif.nxt = 1'b0;
        chk("to_cmd", sif.cmd, 16'h0000);
        for (int i = 0; i < 64; i++) begin
            if (!sif.busy) break;
            tick();
        end
        chk("to_busy", 16'(sif.busy), 16'h0);
        chk("to_err",  16'(sif.err), 16'h1);
        chk("to_lft",  16'(sif.lft_ld), 16'h0000);
        chk("to_upd",  16'(sif.upd), 16'h0);
        conv("to_next", 16'h2000, 16'h0888, 3'b010, 1'b0, 1'b0);
        chk("to_err_sticky", 16'(sif.err), 16'h1);
        chk("to_rght", 16'(sif.rght_ld), 16'h0888);
`else
        chk("err_tied", 16'(sif.err), 16'h0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
